// File: rtl/tetris_pkg.sv
// Shared definitions for the piece rotation logic.
//   PIECE_*       3-bit piece type codes as carried on piece_type
//   rot_dir_e     rotation direction of a request
//   kick_t        signed {dx, dy} candidate offset
//   kick_table()  offset of kick candidate k for a given direction
//   rk_state_e    rotation controller FSM states
package tetris_pkg;

    localparam logic [2:0] PIECE_I = 3'd0;
    localparam logic [2:0] PIECE_O = 3'd1;
    localparam logic [2:0] PIECE_T = 3'd2;
    localparam logic [2:0] PIECE_S = 3'd3;
    localparam logic [2:0] PIECE_Z = 3'd4;
    localparam logic [2:0] PIECE_J = 3'd5;
    localparam logic [2:0] PIECE_L = 3'd6;

    // Largest number of kick candidates the table provides.
    localparam int unsigned MAX_KICKS = 5;

    typedef enum logic {
        ROT_DIR_CW  = 1'b0,
        ROT_DIR_CCW = 1'b1
    } rot_dir_e;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } kick_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StGap  = 2'd2
    } rk_state_e;

    // Candidates are listed for CW; CCW mirrors them horizontally.
    // Index 0 is always the unshifted rotation.
    function automatic kick_t kick_table(rot_dir_e dir, logic [2:0] k);
        kick_t kick;
        kick.dx = 3'sd0;
        kick.dy = 3'sd0;
        case (k)
            3'd1:    kick.dx = -3'sd1;
            3'd2:    kick.dx = 3'sd1;
            3'd3:    kick.dy = -3'sd1;
            3'd4:    kick.dx = -3'sd2;
            default: ;
        endcase
        if (dir == ROT_DIR_CCW) begin
            kick.dx = -kick.dx;
        end
        return kick;
    endfunction

endpackage

// File: rtl/rotate_kick_ctrl_if.sv
// Collision-check handshake between the rotation controller and the board checker.
//   chk_req  controller -> checker  candidate valid, held until chk_ack
//   chk_rot  controller -> checker  candidate orientation
//   chk_dx   controller -> checker  candidate x offset, signed
//   chk_dy   controller -> checker  candidate y offset, signed
//   chk_ack  checker -> controller  response valid
//   chk_ok   checker -> controller  candidate is free; meaningful only with chk_ack
interface rotate_kick_ctrl_if #(
    parameter int unsigned ROT_W = 2
) ();

    logic              chk_req;
    logic [ROT_W-1:0]  chk_rot;
    logic signed [2:0] chk_dx;
    logic signed [2:0] chk_dy;
    logic              chk_ack;
    logic              chk_ok;

    modport master (
        output chk_req,
        output chk_rot,
        output chk_dx,
        output chk_dy,
        input  chk_ack,
        input  chk_ok
    );

    modport slave (
        input  chk_req,
        input  chk_rot,
        input  chk_dx,
        input  chk_dy,
        output chk_ack,
        output chk_ok
    );

endinterface

// File: rtl/key_edge_repeat.sv
// Rising-edge detector with optional auto-repeat for one rotation key.
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   key         key level, synchronous to clock
//   trig        1-cycle trigger: key 0->1 edge, or a repeat tick while held
// REPEAT_DLY = 0 disables auto-repeat; otherwise a tick fires every REPEAT_DLY
// cycles after the edge for as long as the key stays high.
module key_edge_repeat #(
    parameter int unsigned REPEAT_DLY = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key,
    output logic trig
);

    localparam int unsigned CNT_W = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             key_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             key_edge;
    logic             rep_tick;

    always_comb begin
        key_edge = key & ~key_q;
        rep_tick = 1'b0;
        cnt_d    = cnt_q;
        if (!key) begin
            cnt_d = '0;
        end else if (key_edge) begin
            // The edge cycle counts as cycle 1 of the first repeat interval.
            cnt_d = CNT_ONE;
        end else if (REPEAT_DLY != 0) begin
            if (cnt_q == CNT_LAST) begin
                rep_tick = 1'b1;
                cnt_d    = CNT_ONE;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        trig = key_edge | rep_tick;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            key_q <= key;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rotate_kick_ctrl.sv
// Rotation controller for the active piece.
// Turns CW/CCW key edges (with optional auto-repeat) into a rotation request, walks the
// wall-kick candidate list through the board collision checker and commits the first
// accepted candidate.
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   rot_cw      clockwise key level
//   rot_ccw     counter-clockwise key level
//   piece_type  current piece; PIECE_O never rotates
//   spawn       pulse: new piece, orientation back to 0, aborts any search
//   chk         collision-check handshake (master side)
//   rotation    committed orientation, drives the shape ROM address
//   kick_dx/dy  offset applied by the last commit, signed; valid with rot_done
//   rot_done    1-cycle pulse: rotation committed
//   rot_fail    1-cycle pulse: every candidate rejected, or checker timed out
//   busy        search in progress
module rotate_kick_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned NUM_ORIENT  = 4,
    parameter int unsigned ROT_W       = 2,
    parameter int unsigned NUM_KICKS   = 5,
    parameter int unsigned REPEAT_DLY  = 0,
    parameter int unsigned CHK_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rot_cw,
    input  logic              rot_ccw,
    input  logic [2:0]        piece_type,
    input  logic              spawn,
    rotate_kick_ctrl_if.master chk,
    output logic [ROT_W-1:0]  rotation,
    output logic signed [2:0] kick_dx,
    output logic signed [2:0] kick_dy,
    output logic              rot_done,
    output logic              rot_fail,
    output logic              busy
);

    localparam logic [ROT_W-1:0] ROT_LAST  = ROT_W'(NUM_ORIENT - 1);
    localparam logic [2:0]       KICK_LAST = 3'(NUM_KICKS - 1);
    localparam int unsigned      TMO_W     = (CHK_TIMEOUT > 0) ? $clog2(CHK_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((CHK_TIMEOUT > 0) ? CHK_TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

    // Key front end
    logic cw_trig;
    logic ccw_trig;

    key_edge_repeat #(
        .REPEAT_DLY (REPEAT_DLY)
    ) u_cw_key (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (rot_cw),
        .trig    (cw_trig)
    );

    key_edge_repeat #(
        .REPEAT_DLY (REPEAT_DLY)
    ) u_ccw_key (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (rot_ccw),
        .trig    (ccw_trig)
    );

    logic     both_keys;
    logic     cw_fire;
    logic     ccw_fire;
    logic     trig_any;
    rot_dir_e trig_dir;

    // Both keys held is ambiguous, so neither direction fires.
    assign both_keys = rot_cw & rot_ccw;
    assign cw_fire   = cw_trig & ~both_keys;
    assign ccw_fire  = ccw_trig & ~both_keys;
    assign trig_any  = (cw_fire | ccw_fire) && (piece_type != PIECE_O);
    assign trig_dir  = cw_fire ? ROT_DIR_CW : ROT_DIR_CCW;

    // State
    rk_state_e        state_q,    state_d;
    logic [ROT_W-1:0] rotation_q, rotation_d;
    logic [ROT_W-1:0] target_q,   target_d;
    rot_dir_e         dir_q,      dir_d;
    logic [2:0]       kick_idx_q, kick_idx_d;
    kick_t            cand_q,     cand_d;
    kick_t            kick_q,     kick_d;
    logic [TMO_W-1:0] tmo_q,      tmo_d;
    logic             rot_done_q, rot_done_d;
    logic             rot_fail_q, rot_fail_d;

    // Explicit wrap so non-power-of-two orientation counts work.
    logic [ROT_W-1:0] target_cw;
    logic [ROT_W-1:0] target_ccw;

    always_comb begin
        target_cw  = (rotation_q == ROT_LAST) ? '0 : rotation_q + ROT_W'(1);
        target_ccw = (rotation_q == '0) ? ROT_LAST : rotation_q - ROT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        rotation_d = rotation_q;
        target_d   = target_q;
        dir_d      = dir_q;
        kick_idx_d = kick_idx_q;
        cand_d     = cand_q;
        kick_d     = kick_q;
        tmo_d      = tmo_q;
        rot_done_d = 1'b0;
        rot_fail_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trig_any) begin
                    state_d    = StReq;
                    dir_d      = trig_dir;
                    target_d   = (trig_dir == ROT_DIR_CW) ? target_cw : target_ccw;
                    kick_idx_d = 3'd0;
                    cand_d     = kick_table(trig_dir, 3'd0);
                    tmo_d      = '0;
                end
            end

            StReq: begin
                if (chk.chk_ack) begin
                    if (chk.chk_ok) begin
                        rotation_d = target_q;
                        kick_d     = cand_q;
                        rot_done_d = 1'b1;
                        state_d    = StIdle;
                    end else if (kick_idx_q != KICK_LAST) begin
                        kick_idx_d = kick_idx_q + 3'd1;
                        cand_d     = kick_table(dir_q, kick_idx_q + 3'd1);
                        state_d    = StGap;
                    end else begin
                        rot_fail_d = 1'b1;
                        state_d    = StIdle;
                    end
                end else if ((CHK_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    rot_fail_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            // One idle cycle between candidates so the checker sees a fresh request.
            StGap: begin
                state_d = StReq;
                tmo_d   = '0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A new piece overrides everything, including an ack in the same cycle.
        if (spawn) begin
            state_d    = StIdle;
            rotation_d = '0;
            rot_done_d = 1'b0;
            rot_fail_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rotation_q <= '0;
            target_q   <= '0;
            dir_q      <= ROT_DIR_CW;
            kick_idx_q <= '0;
            cand_q     <= '0;
            kick_q     <= '0;
            tmo_q      <= '0;
            rot_done_q <= 1'b0;
            rot_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rotation_q <= rotation_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            kick_idx_q <= kick_idx_d;
            cand_q     <= cand_d;
            kick_q     <= kick_d;
            tmo_q      <= tmo_d;
            rot_done_q <= rot_done_d;
            rot_fail_q <= rot_fail_d;
        end
    end

    // Outputs
    assign chk.chk_req = (state_q == StReq);
    assign chk.chk_rot = target_q;
    assign chk.chk_dx  = cand_q.dx;
    assign chk.chk_dy  = cand_q.dy;

    assign rotation = rotation_q;
    assign kick_dx  = kick_q.dx;
    assign kick_dy  = kick_q.dy;
    assign rot_done = rot_done_q;
    assign rot_fail = rot_fail_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_rotate_kick_ctrl.sv
// Self-checking bench for rotate_kick_ctrl: a scoreboard of expected checker requests
// and expected done/fail results, filled when a key is driven and drained by a monitor.
`timescale 1ns/1ps
module tb_rotate_kick_ctrl;
    import tetris_pkg::*;

    localparam int unsigned NUM_ORIENT  = 4;
    localparam int unsigned ROT_W       = 2;
    localparam int unsigned NUM_KICKS   = 5;
    localparam int unsigned REPEAT_DLY  = 4;
    localparam int unsigned CHK_TIMEOUT = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              rot_cw = 1'b0;
    logic              rot_ccw = 1'b0;
    logic              spawn = 1'b0;
    logic [2:0]        piece_type = PIECE_T;
    logic [ROT_W-1:0]  rotation;
    logic signed [2:0] kick_dx;
    logic signed [2:0] kick_dy;
    logic              rot_done;
    logic              rot_fail;
    logic              busy;

    rotate_kick_ctrl_if #(.ROT_W(ROT_W)) bus ();

    rotate_kick_ctrl #(
        .NUM_ORIENT  (NUM_ORIENT),
        .ROT_W       (ROT_W),
        .NUM_KICKS   (NUM_KICKS),
        .REPEAT_DLY  (REPEAT_DLY),
        .CHK_TIMEOUT (CHK_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rot_cw     (rot_cw),
        .rot_ccw    (rot_ccw),
        .piece_type (piece_type),
        .spawn      (spawn),
        .chk        (bus),
        .rotation   (rotation),
        .kick_dx    (kick_dx),
        .kick_dy    (kick_dy),
        .rot_done   (rot_done),
        .rot_fail   (rot_fail),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Checker model: acks instantly when enabled, accepts only the chosen candidate.
    logic              ack_en = 1'b0;
    int unsigned       accept_k = 0;
    logic signed [2:0] ok_dx = 3'sd0;
    logic signed [2:0] ok_dy = 3'sd0;

    always_comb begin
        bus.chk_ack = bus.chk_req & ack_en;
        bus.chk_ok  = 1'b0;
        if (bus.chk_ack && (accept_k < NUM_KICKS)) begin
            bus.chk_ok = (bus.chk_dx == ok_dx) && (bus.chk_dy == ok_dy);
        end
    end

    // Reference kick offsets
    function automatic void model_kick(input bit ccw, input int k,
                                       output logic signed [2:0] dx,
                                       output logic signed [2:0] dy);
        int x;
        int y;
        x = 0;
        y = 0;
        case (k)
            1:       x = -1;
            2:       x = 1;
            3:       y = -1;
            4:       x = -2;
            default: ;
        endcase
        if (ccw) x = -x;
        dx = 3'(x);
        dy = 3'(y);
    endfunction

    typedef struct packed {
        logic [ROT_W-1:0]  rot;
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } cand_t;

    typedef struct packed {
        logic              fail;
        logic [ROT_W-1:0]  rot;
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } res_t;

    cand_t req_q[$];
    res_t  res_q[$];
    int    m_rot = 0;

    // Queue the expected search for one trigger; acc >= NUM_KICKS means reject all.
    task automatic plan(input bit ccw, input int unsigned acc);
        int    tgt;
        int    last;
        cand_t c;
        res_t  r;
        tgt  = (m_rot + (ccw ? int'(NUM_ORIENT) - 1 : 1)) % int'(NUM_ORIENT);
        last = (acc < NUM_KICKS) ? int'(acc) : int'(NUM_KICKS) - 1;
        for (int k = 0; k <= last; k++) begin
            c.rot = ROT_W'(tgt);
            model_kick(ccw, k, c.dx, c.dy);
            req_q.push_back(c);
        end
        if (acc < NUM_KICKS) begin
            r.fail = 1'b0;
            r.rot  = ROT_W'(tgt);
            model_kick(ccw, int'(acc), r.dx, r.dy);
            m_rot = tgt;
        end else begin
            r.fail = 1'b1;
            r.rot  = ROT_W'(m_rot);
            r.dx   = 3'sd0;
            r.dy   = 3'sd0;
        end
        res_q.push_back(r);
        ack_en   = 1'b1;
        accept_k = acc;
        model_kick(ccw, (acc < NUM_KICKS) ? int'(acc) : 0, ok_dx, ok_dy);
    endtask

    // Checker silent: one request expected, optionally followed by a timeout fail.
    task automatic plan_noack(input bit ccw, input bit with_fail);
        int    tgt;
        cand_t c;
        res_t  r;
        tgt   = (m_rot + (ccw ? int'(NUM_ORIENT) - 1 : 1)) % int'(NUM_ORIENT);
        c.rot = ROT_W'(tgt);
        model_kick(ccw, 0, c.dx, c.dy);
        req_q.push_back(c);
        if (with_fail) begin
            r.fail = 1'b1;
            r.rot  = ROT_W'(m_rot);
            r.dx   = 3'sd0;
            r.dy   = 3'sd0;
            res_q.push_back(r);
        end
        ack_en   = 1'b0;
        accept_k = 0;
        model_kick(ccw, 0, ok_dx, ok_dy);
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor
    int    req_rise_cnt = 0;
    int    done_cnt = 0;
    int    fail_cnt = 0;
    int    last_req_cyc = 0;
    int    last_done_cyc = 0;
    int    last_fail_cyc = 0;
    logic  req_prev = 1'b0;
    cand_t mc;
    res_t  mr;

    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            if (bus.chk_req && !req_prev) begin
                req_rise_cnt++;
                last_req_cyc = cyc;
                check_eq("req_expected", req_q.size() > 0, 1);
                if (req_q.size() > 0) begin
                    mc = req_q.pop_front();
                    check_eq("req_rot", bus.chk_rot, mc.rot);
                    check_eq("req_dx", bus.chk_dx, mc.dx);
                    check_eq("req_dy", bus.chk_dy, mc.dy);
                end
            end
            if (rot_done || rot_fail) begin
                if (rot_done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (rot_fail) begin
                    fail_cnt++;
                    last_fail_cyc = cyc;
                end
                check_eq("pulse_excl", (rot_done && rot_fail) || bus.chk_req, 0);
                check_eq("res_expected", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    mr = res_q.pop_front();
                    check_eq("res_kind", rot_fail, mr.fail);
                    check_eq("res_rotation", rotation, mr.rot);
                    if (rot_done) begin
                        check_eq("res_kick_dx", kick_dx, mr.dx);
                        check_eq("res_kick_dy", kick_dy, mr.dy);
                    end
                end
            end
        end
        req_prev = bus.chk_req;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int trig_cyc = 0;

    task automatic pulse(input bit ccw);
        if (ccw) rot_ccw = 1'b1;
        else     rot_cw  = 1'b1;
        trig_cyc = cyc;
        tick(1);
        rot_cw  = 1'b0;
        rot_ccw = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        check_eq("idle_in_time", busy, 0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int d0;
    int f0;
    int r0;
    int exp_seq [4] = '{1, 2, 3, 0};

    initial begin
        // Reset state
        tick(3);
        check_eq("rst_rotation", rotation, 0);
        check_eq("rst_chk_req", bus.chk_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done_fail", {rot_done, rot_fail}, 0);
        check_eq("rst_kick", {kick_dx, kick_dy}, 0);
        check_eq("rst_chk_cand", {bus.chk_rot, bus.chk_dx, bus.chk_dy}, 0);
        reset_n = 1'b1;
        tick(2);

        // 1: first request accepted, latency
        plan(1'b0, 0);
        pulse(1'b0);
        wait_idle();
        check_eq("t1_req_latency", last_req_cyc, trig_cyc + 1);
        check_eq("t1_done_latency", last_done_cyc, trig_cyc + 2);
        check_eq("t1_rotation", rotation, 1);

        // 2: spawn, four CW steps, CCW wrap from 0
        spawn = 1'b1;
        tick(1);
        spawn = 1'b0;
        m_rot = 0;
        check_eq("t2_spawn_rot", rotation, 0);
        for (int i = 0; i < 4; i++) begin
            plan(1'b0, 0);
            pulse(1'b0);
            wait_idle();
            check_eq("t2_cw_seq", rotation, exp_seq[i]);
        end
        plan(1'b1, 0);
        pulse(1'b1);
        wait_idle();
        check_eq("t2_ccw_wrap", rotation, 3);

        // 3: third kick accepted, both directions
        d0 = done_cnt;
        plan(1'b0, 2);
        pulse(1'b0);
        wait_idle();
        check_eq("t3_one_done", done_cnt - d0, 1);
        check_eq("t3_kick_dx", kick_dx, 1);
        check_eq("t3_rotation", rotation, 0);
        plan(1'b1, 2);
        pulse(1'b1);
        wait_idle();
        check_eq("t3_ccw_kick_dx", kick_dx, 32'hFFFF_FFFF);
        check_eq("t3_ccw_rotation", rotation, 3);

        // 4: every kick rejected, then checker timeout
        f0 = fail_cnt;
        r0 = req_rise_cnt;
        plan(1'b0, NUM_KICKS);
        pulse(1'b0);
        wait_idle();
        check_eq("t4_one_fail", fail_cnt - f0, 1);
        check_eq("t4_five_reqs", req_rise_cnt - r0, 5);
        check_eq("t4_rot_kept", rotation, 3);
        plan_noack(1'b0, 1'b1);
        pulse(1'b0);
        wait_idle();
        check_eq("t4_tmo_latency", last_fail_cyc, trig_cyc + 1 + int'(CHK_TIMEOUT));
        check_eq("t4_tmo_rot_kept", rotation, 3);

        // 5: auto-repeat while held, then both keys together
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) plan(1'b0, 0);
        rot_cw = 1'b1;
        tick(13);
        rot_cw = 1'b0;
        tick(6);
        check_eq("t5_repeat_commits", done_cnt - d0, 4);
        check_eq("t5_rotation", rotation, 3);
        r0 = req_rise_cnt;
        rot_cw  = 1'b1;
        rot_ccw = 1'b1;
        tick(10);
        rot_cw  = 1'b0;
        rot_ccw = 1'b0;
        tick(3);
        check_eq("t5_both_no_req", req_rise_cnt - r0, 0);
        check_eq("t5_both_rot", rotation, 3);

        // 6: spawn during REQ wins over a same-cycle ack
        d0 = done_cnt;
        f0 = fail_cnt;
        plan_noack(1'b1, 1'b0);
        pulse(1'b1);
        tick(3);
        check_eq("t6_in_req", bus.chk_req, 1);
        spawn  = 1'b1;
        ack_en = 1'b1;
        tick(1);
        spawn  = 1'b0;
        ack_en = 1'b0;
        m_rot  = 0;
        check_eq("t6_spawn_req", bus.chk_req, 0);
        check_eq("t6_spawn_busy", busy, 0);
        check_eq("t6_spawn_rot", rotation, 0);
        tick(12);
        check_eq("t6_no_pulses", (done_cnt - d0) + (fail_cnt - f0), 0);

        // 6b: reset mid-REQ after a kicked commit
        plan(1'b0, 2);
        pulse(1'b0);
        wait_idle();
        check_eq("t6_pre_rot", rotation, 1);
        plan_noack(1'b0, 1'b0);
        pulse(1'b0);
        tick(2);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_rot", rotation, 0);
        check_eq("t6_rst_req_busy", {bus.chk_req, busy}, 0);
        check_eq("t6_rst_kick", {kick_dx, kick_dy}, 0);
        check_eq("t6_rst_chk_rot", bus.chk_rot, 0);
        tick(2);
        reset_n = 1'b1;
        m_rot = 0;
        tick(2);

        // 7: O piece never rotates
        piece_type = PIECE_O;
        ack_en = 1'b1;
        r0 = req_rise_cnt;
        pulse(1'b0);
        tick(5);
        check_eq("t7_o_no_req", req_rise_cnt - r0, 0);
        check_eq("t7_o_rot", rotation, 0);
        piece_type = PIECE_T;

        check_eq("sb_req_left", req_q.size(), 0);
        check_eq("sb_res_left", res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
